// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I instruction formats, field bit positions and the canonical NOP.
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_packer.sv
// imm_packer: scatters an immediate into its RV32I format bit positions; range check compiled in with IMM_RANGE_CHECK_EN.
module imm_packer
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_err
);

    always_comb begin
        imm_bits = fmt == FMT_I ? {imm[11:0], 20'b0} :
                   fmt == FMT_S ? {imm[11:5], 13'b0, imm[4:0], 7'b0} :
                   fmt == FMT_B ? {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0} :
                   fmt == FMT_U ? {imm[31:12], 12'b0} :
                   fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0} :
                   32'b0;
`ifdef IMM_RANGE_CHECK_EN
        // A value fits when every bit above the field's sign bit repeats that sign bit.
        range_err = fmt inside {FMT_I, FMT_S} ? imm[31:11] != {21{imm[11]}} :
                    fmt == FMT_B ? imm[31:12] != {20{imm[12]}} || imm[0] :
                    fmt == FMT_J ? imm[31:20] != {12{imm[20]}} || imm[0] :
                    fmt == FMT_U ? imm[11:0] != 12'b0 :
                    1'b0;
`else
        range_err = 1'b0;
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I words from fields behind a one-entry output register with an address counter.
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    logic [ADDR_W-1:0] cnt;
    logic [31:0]       imm_bits, fields, word;
    logic              range_err, illegal, has_rd, has_rs1, has_rs2, has_f3, has_f7, take, drain;

    imm_packer u_pack (
        .fmt       (in_fmt),
        .imm       (in_imm),
        .imm_bits  (imm_bits),
        .range_err (range_err)
    );

    always_comb begin
        illegal = in_fmt > FMT_J;
        has_rd  = in_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
        has_rs1 = in_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        has_rs2 = in_fmt inside {FMT_R, FMT_S, FMT_B};
        has_f3  = in_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        has_f7  = in_fmt == FMT_R;
        fields  = (32'(in_opcode) << OPC_LSB)
                | (has_rd  ? 32'(in_rd)     << RD_LSB  : 32'b0)
                | (has_rs1 ? 32'(in_rs1)    << RS1_LSB : 32'b0)
                | (has_rs2 ? 32'(in_rs2)    << RS2_LSB : 32'b0)
                | (has_f3  ? 32'(in_funct3) << F3_LSB  : 32'b0)
                | (has_f7  ? 32'(in_funct7) << F7_LSB  : 32'b0);
        word    = illegal ? NOP_INSTR : imm_bits | fields;
    end

    assign in_ready = !reset_n || !out_valid || out_ready;
    assign take     = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            cnt       <= BASE_ADDR;
        end else begin
            if (drain)
                cnt <= cnt + 1'b1;
            if (take) begin
                out_valid <= 1'b1;
                out_instr <= word;
                out_err   <= illegal || range_err;
                // A word replacing one leaving this cycle takes the address after it.
                out_addr  <= drain ? cnt + 1'b1 : cnt;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, meaning width of the instruction-memory word address counter.
REQ-002 SHALL provide parameter BASE_ADDR, default 0, meaning the counter value loaded at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports in_valid/in_ready  input/output  1/1  request handshake.
REQ-006 SHALL have port in_fmt  input  3  instruction format: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal.
REQ-007 SHALL have ports in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7  input  7, 5, 5, 5, 3, 7  instruction fields.
REQ-008 SHALL have port in_imm  input  32  signed byte-offset or immediate value.
REQ-009 SHALL have ports out_valid/out_ready  output/input  1/1  result handshake.
REQ-010 SHALL have ports out_instr, out_addr, out_err  output  32, ADDR_W, 1  encoded word, write address, encoding error.

Function
REQ-011 SHALL perform the inverse of the immediate generator: pack in_imm into the format fields so that decoding plus sign extension returns in_imm.
REQ-012 SHALL use I-type packing imm[11:0]->[31:20].
REQ-013 SHALL use S-type packing imm[11:5]->[31:25] and imm[4:0]->[11:7].
REQ-014 SHALL use B-type packing imm[12]->31, imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->7.
REQ-015 SHALL use U-type packing imm[31:12]->[31:12] and J-type packing imm[20]->31, imm[10:1]->[30:21], imm[11]->20, imm[19:12]->[19:12].
REQ-016 SHALL place rd/rs1/rs2/funct3/funct7/opcode at the standard RV32I positions, and only in the formats that carry them; unused fields SHALL be 0.
REQ-017 SHALL contain a one-entry output register: in_ready = !out_valid || out_ready, giving one-cycle latency and full throughput.
REQ-018 SHALL capture a request on in_valid && in_ready and assert out_valid on the next cycle.
REQ-019 SHALL hold out_instr, out_addr and out_err stable while out_valid && !out_ready.
REQ-020 SHALL increment the address counter by 1 on each out_valid && out_ready, wrapping from 2^ADDR_W-1 to 0.
REQ-021 SHALL set out_addr to the counter value at the time of capture.
REQ-022 SHALL, on a simultaneous output accept and new capture, present the new word at out_addr+1 with no bubble.
REQ-023 SHALL, for in_fmt 6 or 7, emit out_instr=32'h00000013 (NOP) with out_err=1.
REQ-024 SHALL consume a word that has out_err=1 normally, including the address increment.

Reset
REQ-025 SHALL, when reset_n=0 at a clock edge, set out_valid=0, out_instr=0, out_err=0 and counter=BASE_ADDR.
REQ-026 SHALL drop any in-flight word on reset, including one held under backpressure.
REQ-027 SHALL hold in_ready=1 while reset_n=0.

Configuration
REQ-028 SHALL compile range checking in when IMM_RANGE_CHECK_EN is defined; out_err=1 when in_imm does not fit the format.
REQ-029 SHALL, with IMM_RANGE_CHECK_EN, apply these ranges: I/S signed 12-bit; B signed 13-bit with bit0=0; J signed 21-bit with bit0=0; U requires imm[11:0]=0.
REQ-030 SHALL, with IMM_RANGE_CHECK_EN, still output the truncated encoding when out_err=1.
REQ-031 SHALL, without IMM_RANGE_CHECK_EN, silently truncate and drive out_err only for illegal in_fmt.

Structure
REQ-032 SHALL take the format enum, the RV32I field bit positions and the NOP constant from the shared package rv32_pkg.
REQ-033 SHALL implement packing in a combinational sub-module imm_packer (fmt, imm -> field bits, range_err); the handshake, output register and counter SHALL live in instr_encoder.

Verification
REQ-034 SHALL verify I fmt, opcode 0x13, rd=1, f3=0, imm=5 -> out_instr=0x00500093, out_addr=0, out_err=0.
REQ-035 SHALL verify B fmt, opcode 0x63, rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3; feeding the result to the immediate generator SHALL return 0xFFFFFFFC.
REQ-036 SHALL verify S fmt, opcode 0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423.
REQ-037 SHALL verify I fmt with imm=2048 or B fmt with imm=3 -> out_err=1 with IMM_RANGE_CHECK_EN and out_err=0 without it.
REQ-038 SHALL verify out_ready=0 for 3 cycles with a second request pending -> in_ready=0 and the outputs stable; then out_ready=1 -> addresses 0,1 consecutive, wrap 255->0 at ADDR_W=8.
REQ-039 SHALL verify reset_n=0 for one cycle while out_valid=1 -> out_valid=0 and the next word issued at BASE_ADDR.
